// File: rtl/eth_speed_detect.sv
// RGMII link-speed / link-presence detector: counts edges of the rx_clk/8 toggle
// over a fixed gtx_clk window, classifies the rate and commits it after repeated agreement.
module eth_speed_detect #(
    parameter int REF_WINDOW     = 1024,
    parameter int THRESH_1000    = 128,
    parameter int THRESH_100     = 16,
    parameter int STABLE_WINDOWS = 4,
    parameter int SYNC_STAGES    = 3
) (
    input  logic                         gtx_clk,
    input  logic                         gtx_rst_n,
    input  logic                         rx_prescale_tog,
    input  logic                         cfg_force_en,
    input  logic [1:0]                   cfg_force_speed,
    output logic [1:0]                   speed,
    output logic                         mii_select,
    output logic                         link_up,
    output logic                         speed_change,
    output logic                         meas_valid,
    output logic [$clog2(REF_WINDOW):0]  edge_count
);
    localparam int RW = $clog2(REF_WINDOW);
    localparam int EW = $clog2(REF_WINDOW) + 1;
    localparam int SW = $clog2(STABLE_WINDOWS + 1);

    localparam logic [RW-1:0] REF_LAST = RW'(REF_WINDOW - 1);
    localparam logic [EW-1:0] T1000    = EW'(THRESH_1000);
    localparam logic [EW-1:0] T100     = EW'(THRESH_100);
    localparam logic [SW-1:0] STAB     = SW'(STABLE_WINDOWS);

    localparam logic [1:0] CL_NONE = 2'd0;
    localparam logic [1:0] CL_10   = 2'd1;
    localparam logic [1:0] CL_100  = 2'd2;
    localparam logic [1:0] CL_1000 = 2'd3;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [RW-1:0]          ref_cnt_q, ref_cnt_d;
    logic [EW-1:0]          edge_cnt_q, edge_cnt_d;
    logic [EW-1:0]          edge_count_q, edge_count_d;
    logic [1:0]             cand_q, cand_d;
    logic [SW-1:0]          stable_cnt_q, stable_cnt_d;
    logic [1:0]             meas_speed_q, meas_speed_d;
    logic [1:0]             speed_q, speed_d;
    logic                   link_up_q, link_up_d;
    logic                   mii_select_q, mii_select_d;
    logic                   speed_change_q, speed_change_d;
    logic                   meas_valid_q, meas_valid_d;

    logic          edge_det, win_end;
    logic [EW-1:0] cnt_nxt;
    logic [1:0]    cls, force_map;
    logic [SW-1:0] stable_upd;

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], rx_prescale_tog};
        edge_det = sync_q[SYNC_STAGES-1] ^ sync_q[SYNC_STAGES-2];
        win_end  = (ref_cnt_q == REF_LAST);

        ref_cnt_d = win_end ? '0 : ref_cnt_q + RW'(1);
        // Count includes the edge seen on the window-end cycle itself
        cnt_nxt   = (edge_det && edge_cnt_q != '1) ? edge_cnt_q + EW'(1) : edge_cnt_q;
        edge_cnt_d = win_end ? '0 : cnt_nxt;

        if (cnt_nxt == '0)        cls = CL_NONE;
        else if (cnt_nxt >= T1000) cls = CL_1000;
        else if (cnt_nxt >= T100)  cls = CL_100;
        else                       cls = CL_10;

        edge_count_d = edge_count_q;
        meas_valid_d = win_end;
        cand_d       = cand_q;
        stable_cnt_d = stable_cnt_q;
        stable_upd   = stable_cnt_q;
        meas_speed_d = meas_speed_q;
        link_up_d    = link_up_q;

        if (win_end) begin
            edge_count_d = cnt_nxt;
            if (cls == cand_q) begin
                stable_upd = (stable_cnt_q == STAB) ? stable_cnt_q : stable_cnt_q + SW'(1);
            end else begin
                cand_d     = cls;
                stable_upd = SW'(1);
            end
            stable_cnt_d = stable_upd;
            // NONE only drops the link; the last measured speed is kept
            if (stable_upd == STAB) begin
                if (cls == CL_NONE) begin
                    link_up_d = 1'b0;
                end else begin
                    link_up_d = 1'b1;
                    case (cls)
                        CL_10:   meas_speed_d = 2'b00;
                        CL_100:  meas_speed_d = 2'b01;
                        default: meas_speed_d = 2'b10;
                    endcase
                end
            end
        end

        force_map      = (cfg_force_speed == 2'b11) ? 2'b10 : cfg_force_speed;
        speed_d        = cfg_force_en ? force_map : meas_speed_d;
        speed_change_d = (speed_d != speed_q);
        mii_select_d   = (speed_q != 2'b10);
    end

    always_ff @(posedge gtx_clk) begin
        if (!gtx_rst_n) begin
            sync_q         <= '0;
            ref_cnt_q      <= '0;
            edge_cnt_q     <= '0;
            edge_count_q   <= '0;
            cand_q         <= CL_NONE;
            stable_cnt_q   <= '0;
            meas_speed_q   <= 2'b10;
            speed_q        <= 2'b10;
            link_up_q      <= 1'b0;
            mii_select_q   <= 1'b0;
            speed_change_q <= 1'b0;
            meas_valid_q   <= 1'b0;
        end else begin
            sync_q         <= sync_d;
            ref_cnt_q      <= ref_cnt_d;
            edge_cnt_q     <= edge_cnt_d;
            edge_count_q   <= edge_count_d;
            cand_q         <= cand_d;
            stable_cnt_q   <= stable_cnt_d;
            meas_speed_q   <= meas_speed_d;
            speed_q        <= speed_d;
            link_up_q      <= link_up_d;
            mii_select_q   <= mii_select_d;
            speed_change_q <= speed_change_d;
            meas_valid_q   <= meas_valid_d;
        end
    end

    assign speed        = speed_q;
    assign mii_select   = mii_select_q;
    assign link_up      = link_up_q;
    assign speed_change = speed_change_q;
    assign meas_valid   = meas_valid_q;
    assign edge_count   = edge_count_q;
endmodule
